axi_lite_spike_responder: RTL

- AXI4-Lite slave (responder) that answers the read-side AXI master of the SNN inference path.
- Buffers 8-bit bin-ratio input bytes pushed by the data source into an internal FIFO, and returns one byte per read of the DATA register.
- Accepts winner-class writes from the master and presents them to downstream logic as a one-cycle result strobe.

---
 rtl/axi_lite_spike_responder.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_spike_responder.sv
// axi_lite_spike_responder
// AXI4-Lite slave that feeds the SNN inference path. The data source pushes
// 8-bit bin-ratio bytes into an internal FIFO. Each read of the DATA register
// pops one byte. Writes to RESULT publish the winning class downstream as a
// one-cycle strobe.
//
// Ports:
//   s_axi_aclk / s_axi_areset    clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w* / s_axi_b*  AXI4-Lite write address, data, response
//   s_axi_ar* / s_axi_r*             AXI4-Lite read address, data
//   in_valid / in_data / in_ready    byte push interface into the FIFO
//   winner_id / winner_valid         last written winner class + strobe
//
// Register map (decoded on addr[3:2]):
//   0x0 DATA   RO  {23'b0, hit, byte}
//   0x4 STATUS RO  [CNT_W-1:0] count, [16] empty, [17] full
//   0x8 RESULT RW  {27'b0, winner_id}
//   0xC CTRL       reads ID_WORD, writing bit0 = 1 flushes the FIFO
module axi_lite_spike_responder #(
   parameter int          FIFO_DEPTH = 16,
   parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1,
   parameter logic [31:0] ID_WORD    = 32'h534E_4E01
) (
   input  logic        s_axi_aclk,
   input  logic        s_axi_areset,
   input  logic [3:0]  s_axi_awaddr,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [3:0]  s_axi_araddr,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [4:0]  winner_id,
   output logic        winner_valid
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] SEL_DATA    = 2'd0;
   localparam logic [1:0] SEL_STATUS  = 2'd1;
   localparam logic [1:0] SEL_RESULT  = 2'd2;
   localparam logic [1:0] SEL_CTRL    = 2'd3;

   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   r_state_t         r_state;
   logic             alive;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;

   logic             aw_latched;
   logic             w_latched;
   logic [1:0]       aw_sel_q;
   logic [4:0]       w_data_q;
   logic             w_strb0_q;

   logic             ar_hs;
   logic             aw_hs;
   logic             w_hs;
   logic             do_write;
   logic [1:0]       wr_sel;
   logic [4:0]       wr_data;
   logic             wr_strb0;
   logic             push;
   logic             pop;
   logic             flush;
   logic [31:0]      status_word;
   logic [31:0]      read_word;
   logic             unused_bits;

   // Only addr[3:2], wdata[4:0] and wstrb[0] carry meaning for this block.
   assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                          s_axi_wdata[31:5], s_axi_wstrb[3:1]};

   // alive holds every ready low while reset is asserted and for the reset edge.
   assign empty         = (count == '0);
   assign full          = (count == CNT_W'(FIFO_DEPTH));
   assign in_ready      = alive && !full;
   assign s_axi_arready = alive && (r_state == R_IDLE);
   assign s_axi_awready = alive && !aw_latched && !s_axi_bvalid;
   assign s_axi_wready  = alive && !w_latched && !s_axi_bvalid;

   assign ar_hs = s_axi_arvalid && s_axi_arready;
   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;

   // A write fires on the edge where the second half (address or data) arrives,
   // so the fields come from the latch if already held, else straight off the bus.
   assign wr_sel   = aw_latched ? aw_sel_q  : s_axi_awaddr[3:2];
   assign wr_data  = w_latched  ? w_data_q  : s_axi_wdata[4:0];
   assign wr_strb0 = w_latched  ? w_strb0_q : s_axi_wstrb[0];
   assign do_write = !s_axi_bvalid && (aw_latched || aw_hs) && (w_latched || w_hs);

   assign flush = do_write && (wr_sel == SEL_CTRL) && wr_data[0] && wr_strb0;
   assign push  = in_valid && in_ready;
   assign pop   = ar_hs && (s_axi_araddr[3:2] == SEL_DATA) && !empty;

   // STATUS word assembly.
   always_comb begin
      status_word              = '0;
      status_word[CNT_W-1:0]   = count;
      status_word[16]          = empty;
      status_word[17]          = full;
   end

   // Read data selected at the AR handshake; DATA on an empty FIFO reads as 0.
   always_comb begin
      read_word = '0;
      case (s_axi_araddr[3:2])
         SEL_DATA:   read_word = empty ? 32'h0 : {23'b0, 1'b1, fifo_mem[rd_ptr]};
         SEL_STATUS: read_word = status_word;
         SEL_RESULT: read_word = {27'b0, winner_id};
         default:    read_word = ID_WORD;
      endcase
   end

   // Tracks whether reset has been released, gating every ready output.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         alive <= 1'b0;
      end else begin
         alive <= 1'b1;
      end
   end

   // Read channel: capture the response at the AR handshake, hold it until rready.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         r_state      <= R_IDLE;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  s_axi_rdata  <= read_word;
                  s_axi_rresp  <= RESP_OKAY;
                  s_axi_rvalid <= 1'b1;
                  r_state      <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  s_axi_rvalid <= 1'b0;
                  r_state      <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Write channel: latch AW and W independently, perform the register update
   // once both are present, then hold the response until bready.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         aw_latched   <= 1'b0;
         w_latched    <= 1'b0;
         aw_sel_q     <= '0;
         w_data_q     <= '0;
         w_strb0_q    <= 1'b0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         winner_id    <= '0;
         winner_valid <= 1'b0;
      end else begin
         winner_valid <= 1'b0;
         if (s_axi_bvalid && s_axi_bready) begin
            aw_latched   <= 1'b0;
            w_latched    <= 1'b0;
            s_axi_bvalid <= 1'b0;
         end else begin
            if (aw_hs) begin
               aw_latched <= 1'b1;
               aw_sel_q   <= s_axi_awaddr[3:2];
            end
            if (w_hs) begin
               w_latched <= 1'b1;
               w_data_q  <= s_axi_wdata[4:0];
               w_strb0_q <= s_axi_wstrb[0];
            end
            if (do_write) begin
               s_axi_bvalid <= 1'b1;
               s_axi_bresp  <= (wr_sel == SEL_DATA || wr_sel == SEL_STATUS) ?
                               RESP_SLVERR : RESP_OKAY;
               if (wr_sel == SEL_RESULT && wr_strb0) begin
                  winner_id    <= wr_data;
                  winner_valid <= 1'b1;
               end
            end
         end
      end
   end

   // FIFO pointers and occupancy; a flush overrides any push or pop that edge.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // FIFO storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge s_axi_aclk) begin
      if (push && !flush) begin
         fifo_mem[wr_ptr] <= in_data;
      end
   end

endmodule
